rx_uart_param: RTL and testbench
================================

RX_UART_PARAM -- requirements
Module: rx_uart_param

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter NB_STOP, default 1, stop bits per frame (legal 1 or 2).
REQ-003 SHALL have parameter N_TICKS, default 16, i_rate ticks per bit (even, legal 8..32).
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-005 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_rate, input, 1, one-cycle oversampling tick from the baud generator.
REQ-008 SHALL have port i_rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port o_data, output, NB_DATA, last received word, LSB = first data bit.
REQ-010 SHALL have port o_rx_done, output, 1, one-cycle pulse when a frame completes.
REQ-011 SHALL have port o_frame_err, output, 1, a stop bit of the last frame sampled low.
REQ-012 SHALL have port o_parity_err, output, 1, parity mismatch in the last frame (tied 0 without UART_RX_PARITY_EN).

Function
REQ-013 SHALL pass i_rx through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle latency).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; tick counter and bit counter are advanced only on i_rate.
REQ-015 IDLE SHALL go to START on a synchronized low only if the line has been seen high since the last frame (armed flag); a held-low line never retriggers.
REQ-016 START SHALL sample at tick N_TICKS/2-1: low -> DATA with tick counter cleared; high -> IDLE (glitch, no o_rx_done, flags unchanged).
REQ-017 DATA SHALL sample at every N_TICKS-th tick, shift LSB-first, and leave after NB_DATA bits to PARITY (macro set) or STOP.
REQ-018 PARITY SHALL sample one bit and flag an error if XOR of data bits, parity bit and PARITY_ODD is 1.
REQ-019 STOP SHALL sample NB_STOP bits at N_TICKS spacing; any low sample sets the frame error for this frame.
REQ-020 After the final stop sample, o_data, o_frame_err and o_parity_err SHALL update and o_rx_done SHALL pulse high in the same cycle; state -> IDLE.
REQ-021 Outputs SHALL hold their values until the next completed frame; a data word is never dropped because of an error.
REQ-022 Ticks arriving while IDLE SHALL have no effect; i_rate held high SHALL advance one tick per cycle.

Reset
REQ-023 While i_rst is high at a clock edge: state IDLE, counters 0, synchronizer flops 1, armed 0, o_data 0, o_rx_done 0, o_frame_err 0, o_parity_err 0.
REQ-024 Reset mid-frame SHALL abort the frame with no o_rx_done; the next frame SHALL be accepted only after the line is seen high.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: the PARITY state exists, frame = start + NB_DATA + parity + NB_STOP bits.
REQ-026 Macro UART_RX_PARITY_EN undefined: the PARITY state and checker are removed, DATA goes directly to STOP, and o_parity_err is constant 0.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state encoding typedef, the parity-mode constants and the legal-range limits for NB_DATA, NB_STOP and N_TICKS.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module named rx_sync (reset value 1); the FSM and datapath stay in rx_uart_param.

Verification
REQ-029 Defaults, no parity, frame 0x53 at 16 ticks/bit -> one o_rx_done pulse, o_data=0x53, both error flags 0.
REQ-030 Parity enabled, even, data 0xA5 with parity bit 0 -> o_data=0xA5, o_parity_err=0; repeat with parity bit 1 -> o_parity_err=1, data still 0xA5.
REQ-031 Stop bit driven low, data 0x3C -> o_rx_done pulses, o_data=0x3C, o_frame_err=1; line held low after that -> no further o_rx_done until it returns high.
REQ-032 Low glitch of 4 ticks on an idle line -> return to IDLE, no o_rx_done, outputs unchanged.
REQ-033 NB_DATA=7, NB_STOP=2, data 0x41 -> o_data=7'h41; second stop bit low -> o_frame_err=1.
REQ-034 i_rst asserted at data bit 3, then a valid 0x0F frame -> no pulse for the aborted frame, o_data=0x0F after the new frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the UART receiver: state encoding,
//           parity-mode constants and legal parameter ranges.
// Config  : UART_RX_PARITY_EN (consumed by rx_uart_param, not by this file)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver state encoding (explicit 3-bit width)
    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_START  = 3'd1;
    localparam state_t c_ST_DATA   = 3'd2;
    localparam state_t c_ST_PARITY = 3'd3;
    localparam state_t c_ST_STOP   = 3'd4;

    // Parity modes for PARITY_ODD
    localparam int c_PARITY_EVEN = 0;
    localparam int c_PARITY_ODD  = 1;

    // Legal parameter ranges
    localparam int c_NB_DATA_MIN = 5;
    localparam int c_NB_DATA_MAX = 9;
    localparam int c_NB_STOP_MIN = 1;
    localparam int c_NB_STOP_MAX = 2;
    localparam int c_N_TICKS_MIN = 8;
    localparam int c_N_TICKS_MAX = 32;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
// Module  : rx_sync
// Purpose : Two-flop synchronizer for the asynchronous serial line. Both
//           flops reset to 1 so a reset never looks like a start bit.
// Ports   : i_clk  - clock
//           i_rst  - synchronous active-high reset
//           i_d    - asynchronous input
//           o_q    - synchronized output (2-cycle latency)
// Revision: 1.0 - initial release
// ============================================================================
module rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : rx_sync
`default_nettype wire

// File: rtl/rx_uart_param.sv
`default_nettype none
// ============================================================================
// Module  : rx_uart_param
// Purpose : Parameterized oversampling UART receiver. Start bit is checked at
//           mid-bit, data is shifted LSB-first, optional parity is checked and
//           NB_STOP stop bits are verified. Results update together with a
//           one-cycle o_rx_done pulse and hold until the next frame.
// Config  : UART_RX_PARITY_EN - when defined, a parity bit follows the data
//           bits and o_parity_err reports mismatches; otherwise it is tied 0.
// Ports   : i_clk        - clock
//           i_rst        - synchronous active-high reset
//           i_rate       - one-cycle oversampling tick (N_TICKS per bit)
//           i_rx         - asynchronous serial line, idle high
//           o_data       - last received word, LSB = first data bit
//           o_rx_done    - one-cycle pulse when a frame completes
//           o_frame_err  - a stop bit of the last frame sampled low
//           o_parity_err - parity mismatch in the last frame
// Revision: 1.0 - initial release
// ============================================================================
module rx_uart_param
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int NB_STOP    = 1,
    parameter int N_TICKS    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rate,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    // ------------------------------------------------------------------
    // Parameter range checks (elaboration time)
    // ------------------------------------------------------------------
    if (NB_DATA < c_NB_DATA_MIN || NB_DATA > c_NB_DATA_MAX) begin : g_bad_nb_data
        $error("rx_uart_param: NB_DATA out of range");
    end
    if (NB_STOP < c_NB_STOP_MIN || NB_STOP > c_NB_STOP_MAX) begin : g_bad_nb_stop
        $error("rx_uart_param: NB_STOP out of range");
    end
    if (N_TICKS < c_N_TICKS_MIN || N_TICKS > c_N_TICKS_MAX || (N_TICKS % 2) != 0) begin : g_bad_n_ticks
        $error("rx_uart_param: N_TICKS must be even and in range");
    end
    if (PARITY_ODD != c_PARITY_EVEN && PARITY_ODD != c_PARITY_ODD) begin : g_bad_parity
        $error("rx_uart_param: PARITY_ODD must be 0 or 1");
    end

    localparam int              c_TW        = $clog2(N_TICKS);
    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(N_TICKS / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(N_TICKS - 1);
    localparam logic [3:0]      c_DATA_LAST = 4'(NB_DATA - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(NB_STOP - 1);

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic w_rx;

    rx_sync u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx)
    );

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_TW-1:0]    r_tick;
    logic [3:0]         r_bit;
    logic [NB_DATA-1:0] r_shift;
    logic               r_armed;     // line seen high since the last frame
    logic               r_ferr_acc;  // low stop sample seen in this frame
    logic [NB_DATA-1:0] r_data;
    logic               r_rx_done;
    logic               r_frame_err;
`ifdef UART_RX_PARITY_EN
    localparam logic    c_ODD_BIT = (PARITY_ODD != 0);
    logic               r_par_bit;
    logic               r_parity_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_ferr_acc  <= 1'b0;
            r_data      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Ticks are ignored here; a start is taken only from a
                    // high-to-low transition, never from a line held low.
                    r_tick <= '0;
                    r_bit  <= '0;
                    if (w_rx) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    if (i_rate) begin
                        if (r_tick == c_TICK_MID) begin
                            r_tick <= '0;
                            r_bit  <= '0;
                            // Still high at mid-bit means a glitch: drop it
                            r_state <= w_rx ? c_ST_IDLE : c_ST_DATA;
                        end else begin
                            r_tick <= r_tick + c_TW'(1);
                        end
                    end
                end

                c_ST_DATA: begin
                    if (i_rate) begin
                        if (r_tick == c_TICK_LAST) begin
                            r_tick  <= '0;
                            r_shift <= {w_rx, r_shift[NB_DATA-1:1]};
                            if (r_bit == c_DATA_LAST) begin
                                r_bit      <= '0;
                                r_ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                r_state    <= c_ST_PARITY;
`else
                                r_state    <= c_ST_STOP;
`endif
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end else begin
                            r_tick <= r_tick + c_TW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                c_ST_PARITY: begin
                    if (i_rate) begin
                        if (r_tick == c_TICK_LAST) begin
                            r_tick    <= '0;
                            r_par_bit <= w_rx;
                            r_state   <= c_ST_STOP;
                        end else begin
                            r_tick <= r_tick + c_TW'(1);
                        end
                    end
                end
`endif

                c_ST_STOP: begin
                    if (i_rate) begin
                        if (r_tick == c_TICK_LAST) begin
                            r_tick <= '0;
                            if (r_bit == c_STOP_LAST) begin
                                // Frame complete: publish everything together
                                r_bit       <= '0;
                                r_data      <= r_shift;
                                r_frame_err <= r_ferr_acc | ~w_rx;
`ifdef UART_RX_PARITY_EN
                                r_parity_err <= (^r_shift) ^ r_par_bit ^ c_ODD_BIT;
`endif
                                r_rx_done   <= 1'b1;
                                r_state     <= c_ST_IDLE;
                            end else begin
                                r_ferr_acc <= r_ferr_acc | ~w_rx;
                                r_bit      <= r_bit + 4'd1;
                            end
                        end else begin
                            r_tick <= r_tick + c_TW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_rx_done   = r_rx_done;
    assign o_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule : rx_uart_param
`default_nettype wire

// File: tb/tb_rx_uart_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_uart_param
// Purpose : Directed self-checking bench for rx_uart_param. Instance A uses
//           the defaults (8N1, 16 ticks/bit); instance B uses NB_DATA=7,
//           NB_STOP=2. i_rate pulses every third clock.
// Config  : UART_RX_PARITY_EN - when defined, frames carry a parity bit and
//           the parity checks are exercised.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rx_uart_param;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rate = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic [7:0] data_a;
    logic       done_a, ferr_a, perr_a;
    logic [6:0] data_b;
    logic       done_b, ferr_b, perr_b;

    int n_vec = 0;
    int n_err = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int div   = 0;

    rx_uart_param u_dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rate       (rate),
        .i_rx         (rx_a),
        .o_data       (data_a),
        .o_rx_done    (done_a),
        .o_frame_err  (ferr_a),
        .o_parity_err (perr_a)
    );

    rx_uart_param #(
        .NB_DATA (7),
        .NB_STOP (2)
    ) u_dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rate       (rate),
        .i_rx         (rx_b),
        .o_data       (data_b),
        .o_rx_done    (done_b),
        .o_frame_err  (ferr_b),
        .o_parity_err (perr_b)
    );

    always #5 clk = ~clk;

    // Baud tick: one pulse every third clock
    always @(negedge clk) begin
        div  = (div == 2) ? 0 : div + 1;
        rate = (div == 0);
    end

    // Count done pulses away from the active edge
    always @(negedge clk) begin
        if (done_a === 1'b1) cnt_a++;
        if (done_b === 1'b1) cnt_b++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (rate !== 1'b1);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic send_bit(input int which, input logic v);
        @(negedge clk);
        drive(which, v);
        wait_ticks(16);
    endtask

    task automatic idle(input int which, input int ticks);
        @(negedge clk);
        drive(which, 1'b1);
        wait_ticks(ticks);
    endtask

    // flip=0 sends the correct even-parity bit; stops[0] is the first stop bit
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input logic flip, input logic [1:0] stops, input int nstop);
        logic par;
        par = flip;
        send_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(which, data[i]);
            par = par ^ data[i];
        end
`ifdef UART_RX_PARITY_EN
        send_bit(which, par);
`endif
        for (int i = 0; i < nstop; i++) send_bit(which, stops[i]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++; if (data_a !== 8'h00) begin n_err++; $display("FAIL reset_data_a: got %h expected 00", data_a); end
        n_vec++; if (done_a !== 1'b0)  begin n_err++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
        n_vec++; if (ferr_a !== 1'b0)  begin n_err++; $display("FAIL reset_ferr_a: got %b expected 0", ferr_a); end
        n_vec++; if (perr_a !== 1'b0)  begin n_err++; $display("FAIL reset_perr_a: got %b expected 0", perr_a); end
        n_vec++; if (data_b !== 7'h00) begin n_err++; $display("FAIL reset_data_b: got %h expected 00", data_b); end
        rst = 1'b0;
        wait_ticks(8);
        n_vec++; if (cnt_a !== 0) begin n_err++; $display("FAIL reset_no_done: got %0d expected 0", cnt_a); end
    endtask

    task automatic test_basic;
        int base;
        base = cnt_a;
        send_frame(0, 9'h053, 8, 1'b0, 2'b11, 1);
        idle(0, 8);
        n_vec++; if (cnt_a - base !== 1) begin n_err++; $display("FAIL basic_done: got %0d expected 1", cnt_a - base); end
        n_vec++; if (data_a !== 8'h53)   begin n_err++; $display("FAIL basic_data: got %h expected 53", data_a); end
        n_vec++; if (ferr_a !== 1'b0)    begin n_err++; $display("FAIL basic_ferr: got %b expected 0", ferr_a); end
        n_vec++; if (perr_a !== 1'b0)    begin n_err++; $display("FAIL basic_perr: got %b expected 0", perr_a); end
    endtask

    task automatic test_parity;
        int base;
        base = cnt_a;
        send_frame(0, 9'h0A5, 8, 1'b0, 2'b11, 1);
        idle(0, 8);
        n_vec++; if (data_a !== 8'hA5) begin n_err++; $display("FAIL par_good_data: got %h expected a5", data_a); end
        n_vec++; if (perr_a !== 1'b0)  begin n_err++; $display("FAIL par_good_perr: got %b expected 0", perr_a); end
`ifdef UART_RX_PARITY_EN
        send_frame(0, 9'h0A5, 8, 1'b1, 2'b11, 1);
        idle(0, 8);
        n_vec++; if (cnt_a - base !== 2) begin n_err++; $display("FAIL par_done: got %0d expected 2", cnt_a - base); end
        n_vec++; if (data_a !== 8'hA5)   begin n_err++; $display("FAIL par_bad_data: got %h expected a5", data_a); end
        n_vec++; if (perr_a !== 1'b1)    begin n_err++; $display("FAIL par_bad_perr: got %b expected 1", perr_a); end
`else
        n_vec++; if (cnt_a - base !== 1) begin n_err++; $display("FAIL par_done: got %0d expected 1", cnt_a - base); end
`endif
    endtask

    task automatic test_frame_err;
        int base;
        base = cnt_a;
        send_frame(0, 9'h03C, 8, 1'b0, 2'b00, 1);
        wait_ticks(200);  // line stays low for many bit times
        n_vec++; if (cnt_a - base !== 1) begin n_err++; $display("FAIL ferr_done: got %0d expected 1", cnt_a - base); end
        n_vec++; if (data_a !== 8'h3C)   begin n_err++; $display("FAIL ferr_data: got %h expected 3c", data_a); end
        n_vec++; if (ferr_a !== 1'b1)    begin n_err++; $display("FAIL ferr_flag: got %b expected 1", ferr_a); end
        idle(0, 8);
        n_vec++; if (cnt_a - base !== 1) begin n_err++; $display("FAIL ferr_no_retrig: got %0d expected 1", cnt_a - base); end
        send_frame(0, 9'h053, 8, 1'b0, 2'b11, 1);
        idle(0, 8);
        n_vec++; if (cnt_a - base !== 2) begin n_err++; $display("FAIL ferr_recover_done: got %0d expected 2", cnt_a - base); end
        n_vec++; if (ferr_a !== 1'b0)    begin n_err++; $display("FAIL ferr_recover_flag: got %b expected 0", ferr_a); end
    endtask

    task automatic test_glitch;
        int base;
        base = cnt_a;
        @(negedge clk);
        rx_a = 1'b0;
        wait_ticks(4);
        idle(0, 40);
        n_vec++; if (cnt_a - base !== 0) begin n_err++; $display("FAIL glitch_done: got %0d expected 0", cnt_a - base); end
        n_vec++; if (data_a !== 8'h53)   begin n_err++; $display("FAIL glitch_data: got %h expected 53", data_a); end
        n_vec++; if (ferr_a !== 1'b0)    begin n_err++; $display("FAIL glitch_ferr: got %b expected 0", ferr_a); end
        send_frame(0, 9'h0C6, 8, 1'b0, 2'b11, 1);
        idle(0, 8);
        n_vec++; if (data_a !== 8'hC6)   begin n_err++; $display("FAIL glitch_after_data: got %h expected c6", data_a); end
    endtask

    task automatic test_nb7_stop2;
        int base;
        base = cnt_b;
        send_frame(1, 9'h041, 7, 1'b0, 2'b11, 2);
        idle(1, 8);
        n_vec++; if (cnt_b - base !== 1) begin n_err++; $display("FAIL nb7_done: got %0d expected 1", cnt_b - base); end
        n_vec++; if (data_b !== 7'h41)   begin n_err++; $display("FAIL nb7_data: got %h expected 41", data_b); end
        n_vec++; if (ferr_b !== 1'b0)    begin n_err++; $display("FAIL nb7_ferr: got %b expected 0", ferr_b); end
        send_frame(1, 9'h041, 7, 1'b0, 2'b01, 2);  // second stop low
        idle(1, 8);
        n_vec++; if (cnt_b - base !== 2) begin n_err++; $display("FAIL nb7_stop2_done: got %0d expected 2", cnt_b - base); end
        n_vec++; if (data_b !== 7'h41)   begin n_err++; $display("FAIL nb7_stop2_data: got %h expected 41", data_b); end
        n_vec++; if (ferr_b !== 1'b1)    begin n_err++; $display("FAIL nb7_stop2_ferr: got %b expected 1", ferr_b); end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        base = cnt_a;
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        @(negedge clk);
        rx_a = 1'b1;      // data bit 3
        wait_ticks(4);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++; if (data_a !== 8'h00)   begin n_err++; $display("FAIL mid_rst_data: got %h expected 00", data_a); end
        idle(0, 40);
        n_vec++; if (cnt_a - base !== 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d expected 0", cnt_a - base); end
        send_frame(0, 9'h00F, 8, 1'b0, 2'b11, 1);
        idle(0, 8);
        n_vec++; if (cnt_a - base !== 1) begin n_err++; $display("FAIL mid_rst_new_done: got %0d expected 1", cnt_a - base); end
        n_vec++; if (data_a !== 8'h0F)   begin n_err++; $display("FAIL mid_rst_new_data: got %h expected 0f", data_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_nb7_stop2();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rx_uart_param
`default_nettype wire
